// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multicycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with HI/LO registers
module mult_div_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [OP_WIDTH-1:0]   op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] hi_o,
    output logic [DATA_WIDTH-1:0] lo_o,
    output logic                  div_by_zero_o
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    localparam logic [OP_WIDTH-1:0] OP_MULTU = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_MULT  = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_DIVU  = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_DIV   = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_MTHI  = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_MTLO  = OP_WIDTH'(5);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [CW-1:0]     r_cnt;
    logic [W:0]        r_hi_acc;    // product upper half / partial remainder
    logic [W-1:0]      r_lo_acc;    // multiplier bits / dividend shifting into quotient
    logic [W-1:0]      r_opnd;      // multiplicand or divisor magnitude
    logic [W-1:0]      r_a_raw;     // original dividend, returned in HI on divide by zero
    logic              r_is_div;
    logic              r_b_zero;
    logic              r_neg_q;     // quotient / product must be negated
    logic              r_neg_r;     // remainder must be negated
    logic [W-1:0]      r_hi;
    logic [W-1:0]      r_lo;
    logic              r_done;
    logic              r_dbz;

    logic              w_is_iter;
    logic              w_signed;
    logic [W-1:0]      w_a_abs;
    logic [W-1:0]      w_b_abs;
    logic [W:0]        w_sum;
    logic [W:0]        w_shift;
    logic [W:0]        w_trial;
    logic [2*W-1:0]    w_prod;
    logic [2*W-1:0]    w_prod_fix;
    logic [W-1:0]      w_quot_fix;
    logic [W-1:0]      w_rem_fix;

    assign w_is_iter = (op_i == OP_MULTU) || (op_i == OP_MULT) ||
                       (op_i == OP_DIVU)  || (op_i == OP_DIV);
    assign w_signed  = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign w_a_abs   = (w_signed && a_i[W-1]) ? (~a_i + 1'b1) : a_i;
    assign w_b_abs   = (w_signed && b_i[W-1]) ? (~b_i + 1'b1) : b_i;

    // One shift-add step: conditionally add the multiplicand into the upper half
    assign w_sum      = r_hi_acc + (r_lo_acc[0] ? {1'b0, r_opnd} : {(W+1){1'b0}});

    // One restoring-division step: shift in next dividend bit, try subtracting the divisor
    assign w_shift    = {r_hi_acc[W-1:0], r_lo_acc[W-1]};
    assign w_trial    = w_shift - {1'b0, r_opnd};

    // Sign correction applied in FIX; most-negative / -1 falls out naturally
    assign w_prod     = {r_hi_acc[W-1:0], r_lo_acc};
    assign w_prod_fix = r_neg_q ? (~w_prod + 1'b1) : w_prod;
    assign w_quot_fix = r_neg_q ? (~r_lo_acc + 1'b1) : r_lo_acc;
    assign w_rem_fix  = r_neg_r ? (~r_hi_acc[W-1:0] + 1'b1) : r_hi_acc[W-1:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: only iterative ops leave IDLE; CALC runs for exactly W bits
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_i && w_is_iter) w_next = S_CALC;
            S_CALC:  if (r_cnt == CW'(W-1)) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs derived from state and result registers
    always_comb begin
        busy_o        = (r_state != S_IDLE);
        done_o        = r_done;
        hi_o          = r_hi;
        lo_o          = r_lo;
        div_by_zero_o = r_dbz;
    end

    // Datapath: operand capture, per-bit iteration, result write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_hi_acc <= '0;
            r_lo_acc <= '0;
            r_opnd   <= '0;
            r_a_raw  <= '0;
            r_is_div <= 1'b0;
            r_b_zero <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        if (w_is_iter) begin
                            r_is_div <= op_i[1];
                            r_neg_q  <= w_signed && (a_i[W-1] ^ b_i[W-1]);
                            r_neg_r  <= w_signed && a_i[W-1];
                            r_hi_acc <= '0;
                            r_lo_acc <= w_a_abs;
                            r_opnd   <= w_b_abs;
                            r_a_raw  <= a_i;
                            r_b_zero <= (b_i == '0);
                            r_cnt    <= '0;
                            r_dbz    <= 1'b0;
                        end else if (op_i == OP_MTHI) begin
                            r_hi   <= a_i;
                            r_done <= 1'b1;
                            r_dbz  <= 1'b0;
                        end else if (op_i == OP_MTLO) begin
                            r_lo   <= a_i;
                            r_done <= 1'b1;
                            r_dbz  <= 1'b0;
                        end
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_is_div) begin
                        if (!w_trial[W]) begin
                            r_hi_acc <= w_trial;
                            r_lo_acc <= {r_lo_acc[W-2:0], 1'b1};
                        end else begin
                            r_hi_acc <= w_shift;
                            r_lo_acc <= {r_lo_acc[W-2:0], 1'b0};
                        end
                    end else begin
                        r_hi_acc <= {1'b0, w_sum[W:1]};
                        r_lo_acc <= {w_sum[0], r_lo_acc[W-1:1]};
                    end
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    if (r_is_div && r_b_zero) begin
                        r_hi  <= r_a_raw;
                        r_lo  <= '1;
                        r_dbz <= 1'b1;
                    end else if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quot_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*W-1:W];
                        r_lo <= w_prod_fix[W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

- Parametrised multicycle integer multiply/divide unit for the MIPS multicycle datapath.
- Extends the 3-bit combinational ALU op set with MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Results go to internal HI/LO registers; mfhi/mflo paths read them.
- Computes iteratively, one bit per clock, with a start/busy/done handshake to the control FSM.

## Interface

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width; any value ≥ 4.
- OP_WIDTH, 3, width of op_i.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start_i  in  1  request; sampled only in IDLE.
- op_i  in  OP_WIDTH  encoding:
  - 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO.
  - 110 and 111 are reserved.
- a_i  in  DATA_WIDTH  multiplicand / dividend / MTHI-MTLO source.
- b_i  in  DATA_WIDTH  multiplier / divisor.
- busy_o  out  1  high while an iterative operation is in progress.
- done_o  out  1  one-cycle completion pulse.
- hi_o  out  DATA_WIDTH  HI register.
- lo_o  out  DATA_WIDTH  LO register.
- div_by_zero_o  out  1  set by DIV/DIVU with b_i = 0; cleared by the next accepted start.

## Operation

- States: IDLE, CALC, FIX.
- In IDLE with start_i = 1 (accept edge):
  - MULT/MULTU/DIV/DIVU:
    - Latch |a_i| and |b_i| (signed ops) or raw values (unsigned ops).
    - Record the result signs; clear div_by_zero_o.
    - Bit counter ← 0; go to CALC.
  - MTHI/MTLO: write a_i into HI/LO on the accept edge; stay in IDLE; done_o = 1 next cycle.
  - Reserved op: no effect, no done_o.
- CALC, multiply: shift-add on a 2·DATA_WIDTH product register, one multiplier bit per cycle.
- CALC, divide: restoring division with a DATA_WIDTH+1-bit partial remainder, one quotient bit per cycle.
- CALC lasts exactly DATA_WIDTH cycles; when the counter reaches DATA_WIDTH-1, go to FIX.
- FIX (one cycle):
  - Apply sign correction and write HI/LO.
  - Pulse done_o; return to IDLE.
- Multiply result: HI = upper half, LO = lower half of the 2·DATA_WIDTH product.
  - MULT negates the full product when the operand signs differ.
- Divide result: LO = quotient, HI = remainder, truncating toward zero.
  - Quotient is negative when the operand signs differ.
  - Remainder takes the sign of the dividend.
- Signed overflow (most-negative / -1): LO = most-negative value, HI = 0. No flag.
- Divide by zero (DIV or DIVU):
  - Same latency as a normal divide.
  - HI = original a_i, LO = all ones, sign correction skipped.
  - div_by_zero_o = 1 from the FIX-edge onward.
- start_i while busy_o = 1: ignored; operands and op are not re-sampled.

## Timing

- Reset (rst_n low, at any time including mid-CALC): state IDLE, counter 0.
  - All outputs 0: busy_o, done_o, hi_o, lo_o, div_by_zero_o.
- Iterative ops:
  - busy_o rises after the accept edge and stays high through CALC and FIX.
  - busy_o falls on the edge that raises done_o.
  - done_o is high for the cycle following edge k+DATA_WIDTH+1, where k is the accept edge. That is 33 edges for DATA_WIDTH = 32.
  - hi_o/lo_o take their new values on the same edge that raises done_o.
  - HI/LO hold their previous values throughout CALC.
- MTHI/MTLO: HI/LO updated and done_o high after the accept edge; busy_o stays 0.
- A new start may be accepted in the cycle where done_o = 1; the next operation has no gap.

## Test plan

1. MULTU 0xFFFFFFFF × 0xFFFFFFFF:
   - HI = 0xFFFFFFFE, LO = 0x00000001.
   - done_o exactly 33 edges after accept; busy_o high for 33 cycles.
2. MULT 0xFFFFFFFD (-3) × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. MULTU 0 × 0x12345678 → HI = LO = 0.
3. Divides:
   - DIVU 100 / 7 → LO = 14, HI = 2.
   - DIV 0xFFFFFFF9 (-7) / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
   - DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
4. Divide by zero: DIVU 5 / 0 → HI = 5, LO = 0xFFFFFFFF, div_by_zero_o = 1.
   - Then MULTU 2 × 3 → div_by_zero_o = 0 after its accept edge; LO = 6.
5. Handshake:
   - MTHI 0x1234 → hi_o = 0x1234 and done_o pulses 1 cycle after accept; busy_o stays 0.
   - Reserved op 110 → no change, no done_o.
   - A start pulse during CALC is ignored; the result matches the original operands.
6. Reset mid-operation:
   - Pull rst_n low at CALC cycle 10 → all outputs 0 immediately.
   - After release, DIVU 9 / 3 → LO = 3, HI = 0 with full latency.
